stopwatch_timebase: RTL and testbench
=====================================

// Module: stopwatch_timebase
// PURPOSE
//  Free-running stopwatch time base. Divides the system clock into 1 ms ticks.
//  Cascades the ticks into ms/s/min/hr registers.
//  Sits between the pulse/clock source and the 7-segment display driver.
//  Adds run control, lap freeze and configurable hour wrap/saturate.
// PARAMETERS
//  PRESCALE  50000  clk cycles per 1 ms tick (>=1)
//  HR_MOD    10     hour modulus; hr counts 0..HR_MOD-1 (>=1, must fit in HR_W)
//  HR_W      7      hr output width
//  SATURATE  0      0: wrap to 0 after max time; 1: hold at max time and stop
// PORTS
//  clk         in   1     system clock, rising edge
//  nreset      in   1     asynchronous, active-low reset
//  start       in   1     1-cycle pulse: begin/resume counting
//  stop        in   1     1-cycle pulse: pause counting
//  clear       in   1     1-cycle pulse: zero time, prescaler and lap
//  lap         in   1     1-cycle pulse: toggle lap freeze of outputs
//  ms          out  10    milliseconds 0..999
//  s           out  6     seconds 0..59
//  min         out  6     minutes 0..59
//  hr          out  HR_W  hours 0..HR_MOD-1
//  running     out  1     1 while counting
//  lap_active  out  1     1 while outputs show the frozen lap value
//  wrap        out  1     1-cycle pulse on max-time rollover/saturation
// BEHAVIOUR
//  - Reset (nreset=0, async): all counters, lap registers, the prescaler, running,
//    lap_active and wrap are 0. Outputs read 0:00:00.000.
//  - Run control FSM has states STOP (running=0) and RUN (running=1).
//    - Priority in one cycle: clear > stop > start.
//    - STOP->RUN on start. RUN->STOP on stop.
//    - start+stop in the same cycle: stop wins.
//  - clear zeroes time, prescaler and lap_active. It does not change the run state.
//    clear+start from STOP: counters are 0 and the FSM enters RUN.
//  - Prescaler pre counts 0..PRESCALE-1 only in RUN.
//    - tick = RUN && pre==PRESCALE-1; pre returns to 0 on that edge.
//    - pre is retained across stop/start, so no time is lost or gained.
//    - PRESCALE=1 gives a tick every RUN cycle.
//  - On a tick, ms increments on the same edge. Carries ripple in that edge:
//    - ms 999->0 carries to s.
//    - s 59->0 carries to min.
//    - min 59->0 carries to hr.
//  - Max time is HR_MOD-1:59:59.999. A tick at max time does:
//    - SATURATE=0: all fields go to 0, wrap=1 for one cycle, stays in RUN.
//    - SATURATE=1: fields hold at max, wrap=1 for one cycle, FSM -> STOP.
//      A later start at max re-enters RUN, but counters still hold.
//      Each further tick at max re-pulses wrap and stops again.
//  - Lap:
//    - lap while lap_active=0 captures the counter values before this edge's
//      update and sets lap_active.
//    - lap while lap_active=1 clears lap_active.
//    - Lap works in STOP and RUN. Internal counting is never affected by lap.
//    - clear wins over a simultaneous lap.
//  - Outputs are registered values with no combinational path from inputs:
//    lap_active ? lap registers : live counters.
//  - nreset mid-run aborts immediately to the reset state.
//    Counting resumes only on a later start.
// TESTING (PRESCALE=2, HR_MOD=2 unless noted)
//  1. Reset, then start, then 2000 clk:
//     -> 0:00:01.000, running=1, wrap never asserted.
//  2. Run 1001 clk, stop, idle 50 clk, start, run 999 clk:
//     -> exactly 0:00:01.000 (prescaler retained).
//     start+stop in the same cycle -> running=0.
//  3. Preload by running to 0:00:59.999, then one tick -> 0:01:00.000.
//     At 0:59:59.999, one tick -> 1:00:00.000.
//  4. At 1:59:59.999, one tick:
//     - SATURATE=0 -> 0:00:00.000, wrap high exactly 1 cycle, running=1.
//     - SATURATE=1 -> holds 1:59:59.999, wrap 1 cycle, running=0.
//  5. lap at 0:00:01.234 -> outputs frozen at 1.234 and lap_active=1 for 1000 clk.
//     Second lap -> live 0:00:01.734, lap_active=0.
//  6. clear+lap+start while stopped -> 0:00:00.000, lap_active=0, running=1.
//     nreset pulse mid-run (async, between edges) -> all outputs 0 immediately.

Source files
------------

// File: rtl/stopwatch_timebase.sv
// ============================================================================
// stopwatch_timebase
//
// Free-running stopwatch time base. The system clock is divided down to a
// 1 ms tick, and the ticks are cascaded into millisecond, second, minute and
// hour registers. Run control, a lap freeze of the displayed value and a
// choice of wrap or saturate at maximum time are layered on top. The block
// sits between the clock source and the 7-segment display driver.
//
// Parameters
//   PRESCALE   clk cycles per 1 ms tick (>= 1)
//   HR_MOD     hour modulus, hr counts 0..HR_MOD-1 (>= 1, must fit in HR_W)
//   HR_W       width of the hr output
//   SATURATE   0: wrap to zero after max time, 1: hold at max time and stop
//
// Ports
//   clk         in   1     system clock, rising edge
//   nreset      in   1     asynchronous, active-low reset
//   start       in   1     one-cycle pulse, begin/resume counting
//   stop        in   1     one-cycle pulse, pause counting
//   clear       in   1     one-cycle pulse, zero time, prescaler and lap
//   lap         in   1     one-cycle pulse, toggle lap freeze of the outputs
//   ms          out  10    milliseconds 0..999
//   s           out  6     seconds 0..59
//   min         out  6     minutes 0..59
//   hr          out  HR_W  hours 0..HR_MOD-1
//   running     out  1     high while counting
//   lap_active  out  1     high while the outputs show the frozen lap value
//   wrap        out  1     one-cycle pulse on max-time rollover/saturation
// ============================================================================
module stopwatch_timebase #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned HR_MOD   = 10,
    parameter int unsigned HR_W     = 7,
    parameter bit          SATURATE = 1'b0
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            start,
    input  logic            stop,
    input  logic            clear,
    input  logic            lap,
    output logic [9:0]      ms,
    output logic [5:0]      s,
    output logic [5:0]      min,
    output logic [HR_W-1:0] hr,
    output logic            running,
    output logic            lap_active,
    output logic            wrap
);

    // A one-cycle prescaler still needs a one-bit register to keep the
    // declarations legal; it simply never leaves zero.
    localparam int unsigned    PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [HR_W-1:0]  HR_MAX  = HR_W'(HR_MOD - 1);
    localparam logic [9:0]       MS_MAX  = 10'd999;
    localparam logic [5:0]       SM_MAX  = 6'd59;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_next;

    logic [9:0]       ms_cnt;
    logic [5:0]       s_cnt;
    logic [5:0]       min_cnt;
    logic [HR_W-1:0]  hr_cnt;
    logic [9:0]       ms_next;
    logic [5:0]       s_next;
    logic [5:0]       min_next;
    logic [HR_W-1:0]  hr_next;

    logic [9:0]       lap_ms;
    logic [5:0]       lap_s;
    logic [5:0]       lap_min;
    logic [HR_W-1:0]  lap_hr;
    logic [9:0]       lap_ms_next;
    logic [5:0]       lap_s_next;
    logic [5:0]       lap_min_next;
    logic [HR_W-1:0]  lap_hr_next;
    logic             lap_active_next;

    logic             wrap_next;
    logic             tick;
    logic             at_max;
    logic             sat_hit;

    // The 1 ms tick is a function of the current state only; a stop pulse
    // arriving on a tick edge still lets that edge count, which keeps the
    // total elapsed time exact across stop/start.
    assign tick    = (state == ST_RUN) && (pre_cnt == PRE_MAX);

    assign at_max  = (ms_cnt == MS_MAX) && (s_cnt == SM_MAX) &&
                     (min_cnt == SM_MAX) && (hr_cnt == HR_MAX);

    // A saturating tick forces the FSM back to STOP; clear suppresses the
    // tick entirely because it zeroes the counters on the same edge.
    assign sat_hit = SATURATE && tick && at_max && !clear;

    // Run control: stop (and a saturating tick) beat start; clear never
    // touches the run state.
    always_comb begin
        state_next = state;
        if (stop || sat_hit) begin
            state_next = ST_STOP;
        end else if (start) begin
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    // Prescaler and time cascade. All carries ripple within the tick edge.
    // At max time the fields either roll over to zero or are left untouched
    // when saturating; either way wrap pulses for one cycle.
    always_comb begin
        pre_next  = pre_cnt;
        ms_next   = ms_cnt;
        s_next    = s_cnt;
        min_next  = min_cnt;
        hr_next   = hr_cnt;
        wrap_next = 1'b0;

        if (clear) begin
            pre_next = '0;
            ms_next  = '0;
            s_next   = '0;
            min_next = '0;
            hr_next  = '0;
        end else if (state == ST_RUN) begin
            if (tick) begin
                pre_next = '0;
                if (at_max) begin
                    wrap_next = 1'b1;
                    if (!SATURATE) begin
                        ms_next  = '0;
                        s_next   = '0;
                        min_next = '0;
                        hr_next  = '0;
                    end
                end else if (ms_cnt == MS_MAX) begin
                    ms_next = '0;
                    if (s_cnt == SM_MAX) begin
                        s_next = '0;
                        if (min_cnt == SM_MAX) begin
                            min_next = '0;
                            hr_next  = hr_cnt + HR_W'(1);
                        end else begin
                            min_next = min_cnt + 6'd1;
                        end
                    end else begin
                        s_next = s_cnt + 6'd1;
                    end
                end else begin
                    ms_next = ms_cnt + 10'd1;
                end
            end else begin
                pre_next = pre_cnt + PRE_W'(1);
            end
        end
    end

    // Lap toggle. Capture takes the counter values from before this edge's
    // update so the frozen value is the time at which lap was pressed.
    always_comb begin
        lap_ms_next     = lap_ms;
        lap_s_next      = lap_s;
        lap_min_next    = lap_min;
        lap_hr_next     = lap_hr;
        lap_active_next = lap_active;

        if (clear) begin
            lap_ms_next     = '0;
            lap_s_next      = '0;
            lap_min_next    = '0;
            lap_hr_next     = '0;
            lap_active_next = 1'b0;
        end else if (lap) begin
            if (!lap_active) begin
                lap_ms_next     = ms_cnt;
                lap_s_next      = s_cnt;
                lap_min_next    = min_cnt;
                lap_hr_next     = hr_cnt;
                lap_active_next = 1'b1;
            end else begin
                lap_active_next = 1'b0;
            end
        end
    end

    // Time, prescaler and wrap registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
            s_cnt   <= '0;
            min_cnt <= '0;
            hr_cnt  <= '0;
            wrap    <= 1'b0;
        end else begin
            pre_cnt <= pre_next;
            ms_cnt  <= ms_next;
            s_cnt   <= s_next;
            min_cnt <= min_next;
            hr_cnt  <= hr_next;
            wrap    <= wrap_next;
        end
    end

    // Lap registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lap_ms     <= '0;
            lap_s      <= '0;
            lap_min    <= '0;
            lap_hr     <= '0;
            lap_active <= 1'b0;
        end else begin
            lap_ms     <= lap_ms_next;
            lap_s      <= lap_s_next;
            lap_min    <= lap_min_next;
            lap_hr     <= lap_hr_next;
            lap_active <= lap_active_next;
        end
    end

    // Displayed value is chosen purely from registers, so no input reaches
    // the outputs combinationally.
    assign ms      = lap_active ? lap_ms  : ms_cnt;
    assign s       = lap_active ? lap_s   : s_cnt;
    assign min     = lap_active ? lap_min : min_cnt;
    assign hr      = lap_active ? lap_hr  : hr_cnt;
    assign running = (state == ST_RUN);

endmodule

// File: tb/tb_stopwatch_timebase.sv
// ============================================================================
// tb_stopwatch_timebase
//
// Directed bench for stopwatch_timebase with PRESCALE=2, HR_MOD=2. Two copies
// of the design share the same stimulus: one wraps at max time, the other
// saturates. Inputs change 1 time unit after a rising edge and outputs are
// sampled at the same point, well away from the next edge.
// ============================================================================
module tb_stopwatch_timebase;

    localparam int unsigned PRESCALE = 2;
    localparam int unsigned HR_MOD   = 2;
    localparam int unsigned HR_W     = 7;

    logic clk;
    logic nreset;
    logic start;
    logic stop;
    logic clear;
    logic lap;

    logic [9:0]      w_ms;
    logic [5:0]      w_s;
    logic [5:0]      w_min;
    logic [HR_W-1:0] w_hr;
    logic            w_running;
    logic            w_lap_active;
    logic            w_wrap;

    logic [9:0]      s_ms;
    logic [5:0]      s_s;
    logic [5:0]      s_min;
    logic [HR_W-1:0] s_hr;
    logic            s_running;
    logic            s_lap_active;
    logic            s_wrap;

    logic [9:0]      pl_ms;
    logic [5:0]      pl_s;
    logic [5:0]      pl_min;
    logic [HR_W-1:0] pl_hr;
    logic [0:0]      pl_pre;

    int vectors;
    int miscompares;

    stopwatch_timebase #(
        .PRESCALE (PRESCALE),
        .HR_MOD   (HR_MOD),
        .HR_W     (HR_W),
        .SATURATE (1'b0)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .lap        (lap),
        .ms         (w_ms),
        .s          (w_s),
        .min        (w_min),
        .hr         (w_hr),
        .running    (w_running),
        .lap_active (w_lap_active),
        .wrap       (w_wrap)
    );

    stopwatch_timebase #(
        .PRESCALE (PRESCALE),
        .HR_MOD   (HR_MOD),
        .HR_W     (HR_W),
        .SATURATE (1'b1)
    ) dut_sat (
        .clk        (clk),
        .nreset     (nreset),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .lap        (lap),
        .ms         (s_ms),
        .s          (s_s),
        .min        (s_min),
        .hr         (s_hr),
        .running    (s_running),
        .lap_active (s_lap_active),
        .wrap       (s_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed time {hr, min, s, ms} for compact comparisons and printing.
    function automatic logic [28:0] tv(input int h, input int m, input int sec, input int msv);
        return {7'(h), 6'(m), 6'(sec), 10'(msv)};
    endfunction

    function automatic logic [28:0] now_w();
        return {w_hr, w_min, w_s, w_ms};
    endfunction

    function automatic logic [28:0] now_s();
        return {s_hr, s_min, s_s, s_ms};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic st, input logic sp, input logic cl, input logic lp);
        start = st;
        stop  = sp;
        clear = cl;
        lap   = lp;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        lap   = 1'b0;
    endtask

    // Deposits a time and prescaler value into both copies while they are
    // stopped; the forced value is clocked into the registers before release.
    task automatic preload(input int h, input int m, input int sec, input int msv, input int pr);
        pl_hr  = 7'(h);
        pl_min = 6'(m);
        pl_s   = 6'(sec);
        pl_ms  = 10'(msv);
        pl_pre = 1'(pr);
        force dut.hr_cnt      = pl_hr;
        force dut.min_cnt     = pl_min;
        force dut.s_cnt       = pl_s;
        force dut.ms_cnt      = pl_ms;
        force dut.pre_cnt     = pl_pre;
        force dut_sat.hr_cnt  = pl_hr;
        force dut_sat.min_cnt = pl_min;
        force dut_sat.s_cnt   = pl_s;
        force dut_sat.ms_cnt  = pl_ms;
        force dut_sat.pre_cnt = pl_pre;
        step(1);
        release dut.hr_cnt;
        release dut.min_cnt;
        release dut.s_cnt;
        release dut.ms_cnt;
        release dut.pre_cnt;
        release dut_sat.hr_cnt;
        release dut_sat.min_cnt;
        release dut_sat.s_cnt;
        release dut_sat.ms_cnt;
        release dut_sat.pre_cnt;
    endtask

    task automatic test_reset;
        nreset = 1'b1;
        #2 nreset = 1'b0;
        #1;
        vectors++;
        if (now_w() !== tv(0, 0, 0, 0)) begin
            miscompares++;
            $display("[TB] FAIL reset_time got %h want %h", now_w(), tv(0, 0, 0, 0));
        end
        vectors++;
        if ({w_running, w_lap_active, w_wrap} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got %b want 000", {w_running, w_lap_active, w_wrap});
        end
        vectors++;
        if ({now_s(), s_running, s_lap_active, s_wrap} !== {tv(0, 0, 0, 0), 3'b000}) begin
            miscompares++;
            $display("[TB] FAIL reset_sat got %h/%b want 0/000", now_s(), {s_running, s_lap_active, s_wrap});
        end
        @(posedge clk);
        @(posedge clk);
        #1 nreset = 1'b1;
    endtask

    task automatic test_count;
        logic wrap_seen;
        wrap_seen = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (w_wrap) wrap_seen = 1'b1;
            if (i == 999) begin
                vectors++;
                if (now_w() !== tv(0, 0, 0, 500)) begin
                    miscompares++;
                    $display("[TB] FAIL count_half got %h want %h", now_w(), tv(0, 0, 0, 500));
                end
            end
        end
        vectors++;
        if (now_w() !== tv(0, 0, 1, 0)) begin
            miscompares++;
            $display("[TB] FAIL count_1s got %h want %h", now_w(), tv(0, 0, 1, 0));
        end
        vectors++;
        if (w_running !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL count_running got %b want 1", w_running);
        end
        vectors++;
        if (wrap_seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL count_wrap got %b want 0", wrap_seen);
        end
    endtask

    task automatic test_stop_start;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({now_w(), w_running} !== {tv(0, 0, 0, 0), 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL clear_stopped got %h/%b want 0/0", now_w(), w_running);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(1001);
        // The stop edge itself is still a counting edge: 1002 edges, 501 ticks.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({now_w(), w_running} !== {tv(0, 0, 0, 501), 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL stop_hold got %h/%b want %h/0", now_w(), w_running, tv(0, 0, 0, 501));
        end
        step(50);
        vectors++;
        if (now_w() !== tv(0, 0, 0, 501)) begin
            miscompares++;
            $display("[TB] FAIL idle_hold got %h want %h", now_w(), tv(0, 0, 0, 501));
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(999);
        vectors++;
        if (now_w() !== tv(0, 0, 1, 0)) begin
            miscompares++;
            $display("[TB] FAIL resume_exact got %h want %h", now_w(), tv(0, 0, 1, 0));
        end
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (w_running !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_stop_same got %b want 0", w_running);
        end
    endtask

    task automatic test_carry;
        preload(0, 0, 59, 999, 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        vectors++;
        if (now_w() !== tv(0, 1, 0, 0)) begin
            miscompares++;
            $display("[TB] FAIL carry_min got %h want %h", now_w(), tv(0, 1, 0, 0));
        end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        preload(0, 59, 59, 999, 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        vectors++;
        if (now_w() !== tv(1, 0, 0, 0)) begin
            miscompares++;
            $display("[TB] FAIL carry_hr got %h want %h", now_w(), tv(1, 0, 0, 0));
        end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_max;
        preload(1, 59, 59, 999, 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        vectors++;
        if ({now_w(), w_wrap, w_running} !== {tv(0, 0, 0, 0), 2'b11}) begin
            miscompares++;
            $display("[TB] FAIL wrap_roll got %h/%b%b want 0/11", now_w(), w_wrap, w_running);
        end
        vectors++;
        if ({now_s(), s_wrap, s_running} !== {tv(1, 59, 59, 999), 2'b10}) begin
            miscompares++;
            $display("[TB] FAIL sat_hold got %h/%b%b want %h/10", now_s(), s_wrap, s_running, tv(1, 59, 59, 999));
        end
        step(1);
        vectors++;
        if ({w_wrap, s_wrap, w_running} !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL wrap_one_cycle got %b want 001", {w_wrap, s_wrap, w_running});
        end
        // Restart the saturated copy: it runs again but cannot advance.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({now_s(), s_running, s_wrap} !== {tv(1, 59, 59, 999), 2'b10}) begin
            miscompares++;
            $display("[TB] FAIL sat_restart got %h/%b%b want %h/10", now_s(), s_running, s_wrap, tv(1, 59, 59, 999));
        end
        step(2);
        vectors++;
        if ({now_s(), s_wrap, s_running} !== {tv(1, 59, 59, 999), 2'b10}) begin
            miscompares++;
            $display("[TB] FAIL sat_repulse got %h/%b%b want %h/10", now_s(), s_wrap, s_running, tv(1, 59, 59, 999));
        end
        vectors++;
        if (now_w() !== tv(0, 0, 0, 2)) begin
            miscompares++;
            $display("[TB] FAIL wrap_continue got %h want %h", now_w(), tv(0, 0, 0, 2));
        end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_lap;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(2468);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if ({now_w(), w_lap_active} !== {tv(0, 0, 1, 234), 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL lap_capture got %h/%b want %h/1", now_w(), w_lap_active, tv(0, 0, 1, 234));
        end
        step(499);
        vectors++;
        if (now_w() !== tv(0, 0, 1, 234)) begin
            miscompares++;
            $display("[TB] FAIL lap_frozen_mid got %h want %h", now_w(), tv(0, 0, 1, 234));
        end
        step(500);
        vectors++;
        if ({now_w(), w_lap_active} !== {tv(0, 0, 1, 234), 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL lap_frozen_end got %h/%b want %h/1", now_w(), w_lap_active, tv(0, 0, 1, 234));
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if ({now_w(), w_lap_active} !== {tv(0, 0, 1, 734), 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL lap_release got %h/%b want %h/0", now_w(), w_lap_active, tv(0, 0, 1, 734));
        end
    endtask

    task automatic test_clear_reset;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if ({now_w(), w_lap_active, w_running} !== {tv(0, 0, 1, 735), 2'b10}) begin
            miscompares++;
            $display("[TB] FAIL lap_stopped got %h/%b%b want %h/10", now_w(), w_lap_active, w_running, tv(0, 0, 1, 735));
        end
        pulse(1'b1, 1'b0, 1'b1, 1'b1);
        vectors++;
        if ({now_w(), w_lap_active, w_running} !== {tv(0, 0, 0, 0), 2'b01}) begin
            miscompares++;
            $display("[TB] FAIL clear_lap_start got %h/%b%b want 0/01", now_w(), w_lap_active, w_running);
        end
        step(10);
        vectors++;
        if (now_w() !== tv(0, 0, 0, 5)) begin
            miscompares++;
            $display("[TB] FAIL after_clear got %h want %h", now_w(), tv(0, 0, 0, 5));
        end
        #2 nreset = 1'b0;
        #1;
        vectors++;
        if ({now_w(), w_running, w_lap_active, w_wrap} !== {tv(0, 0, 0, 0), 3'b000}) begin
            miscompares++;
            $display("[TB] FAIL async_reset got %h/%b want 0/000", now_w(), {w_running, w_lap_active, w_wrap});
        end
        #1 nreset = 1'b1;
        step(10);
        vectors++;
        if ({now_w(), w_running} !== {tv(0, 0, 0, 0), 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_idle got %h/%b want 0/0", now_w(), w_running);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(4);
        vectors++;
        if ({now_w(), w_running} !== {tv(0, 0, 0, 2), 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reset_resume got %h/%b want %h/1", now_w(), w_running, tv(0, 0, 0, 2));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nreset      = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        clear       = 1'b0;
        lap         = 1'b0;
        pl_ms       = '0;
        pl_s        = '0;
        pl_min      = '0;
        pl_hr       = '0;
        pl_pre      = '0;

        test_reset();
        test_count();
        test_stop_start();
        test_carry();
        test_max();
        test_lap();
        test_clear_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
